// File: rtl/bus_sync_hs.sv
// bus_sync_hs: carries a source-domain data bus into the CLK domain.
// The BUS_ENABLE level is synchronized and edge-detected. Each rising edge
// either captures UNSYNC_BUS into a one-word holding register, or, if that
// register is still full and not being consumed, counts a dropped word.
//
// Ports:
//   CLK          destination-domain clock, rising edge
//   RST          asynchronous active-low reset
//   UNSYNC_BUS   source-domain data, stable while BUS_ENABLE is high
//   BUS_ENABLE   asynchronous level qualifying UNSYNC_BUS
//   BUS_READY    downstream accepts SYNC_BUS when high with BUS_VALID
//   OVERRUN_CLR  clears OVERRUN and DROP_CNT
//   SYNC_BUS     captured data (changes only on acceptance)
//   ENABLE_PULSE one-cycle strobe per accepted capture
//   BUS_VALID    SYNC_BUS holds unconsumed data
//   OVERRUN      sticky dropped-word flag
//   DROP_CNT     saturating dropped-word count
module bus_sync_hs #(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned BUS_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 BUS_ENABLE,
  input  logic                 BUS_READY,
  input  logic                 OVERRUN_CLR,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic                 BUS_VALID,
  output logic                 OVERRUN,
  output logic [3:0]           DROP_CNT
);

  logic [NUM_STAGES-1:0] sync_q;
  logic                  en_prev;
  logic                  en_edge;
  logic                  accept;
  logic                  drop;
  logic                  consume;

  // Rising edge of the synchronized enable; held-high levels and falling
  // edges produce nothing.
  always_comb begin
    en_edge = sync_q[NUM_STAGES-1] & ~en_prev;
    accept  = en_edge & (~BUS_VALID | BUS_READY);
    drop    = en_edge & BUS_VALID & ~BUS_READY;
    consume = BUS_VALID & BUS_READY & ~accept;
  end

  // Synchronizer chain plus the previous-value flop. Both reset to 0, so an
  // enable already high when reset releases is seen as a fresh rising edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q  <= '0;
      en_prev <= 1'b0;
    end else begin
      sync_q  <= {sync_q[NUM_STAGES-2:0], BUS_ENABLE};
      en_prev <= sync_q[NUM_STAGES-1];
    end
  end

  // Holding register and handshake.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      SYNC_BUS     <= '0;
      ENABLE_PULSE <= 1'b0;
      BUS_VALID    <= 1'b0;
    end else begin
      ENABLE_PULSE <= accept;
      if (accept) begin
        SYNC_BUS  <= UNSYNC_BUS;
        BUS_VALID <= 1'b1;
      end else if (consume) begin
        BUS_VALID <= 1'b0;
      end
    end
  end

  // Overrun tracking. A drop in the same cycle as a clear wins and restarts
  // the count at 1 rather than incrementing the old value.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OVERRUN  <= 1'b0;
      DROP_CNT <= '0;
    end else if (drop) begin
      OVERRUN <= 1'b1;
      if (OVERRUN_CLR) begin
        DROP_CNT <= 4'd1;
      end else if (DROP_CNT != 4'hF) begin
        DROP_CNT <= DROP_CNT + 4'd1;
      end
    end else if (OVERRUN_CLR) begin
      OVERRUN  <= 1'b0;
      DROP_CNT <= '0;
    end
  end

endmodule

// File: tb/tb_bus_sync_hs.sv
module tb_bus_sync_hs;

  logic       CLK;
  logic       RST;
  logic [7:0] UNSYNC_BUS;
  logic       BUS_ENABLE;
  logic       BUS_READY;
  logic       OVERRUN_CLR;
  logic [7:0] SYNC_BUS;
  logic       ENABLE_PULSE;
  logic       BUS_VALID;
  logic       OVERRUN;
  logic [3:0] DROP_CNT;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  bus_sync_hs #(
    .NUM_STAGES(2),
    .BUS_WIDTH (8)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .UNSYNC_BUS  (UNSYNC_BUS),
    .BUS_ENABLE  (BUS_ENABLE),
    .BUS_READY   (BUS_READY),
    .OVERRUN_CLR (OVERRUN_CLR),
    .SYNC_BUS    (SYNC_BUS),
    .ENABLE_PULSE(ENABLE_PULSE),
    .BUS_VALID   (BUS_VALID),
    .OVERRUN     (OVERRUN),
    .DROP_CNT    (DROP_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Counts strobes, sampled on the falling edge.
  always @(negedge CLK) begin
    if (ENABLE_PULSE) pulse_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Raise enable and step two edges; en_edge is now live for the next edge.
  task automatic raise_en(input logic [7:0] data);
    UNSYNC_BUS = data;
    BUS_ENABLE = 1'b1;
    tick();
    tick();
  endtask

  // Drop enable and let the synchronizer settle back to 0.
  task automatic lower_en();
    BUS_ENABLE = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    RST         = 1'b0;
    UNSYNC_BUS  = 8'h00;
    BUS_ENABLE  = 1'b0;
    BUS_READY   = 1'b0;
    OVERRUN_CLR = 1'b0;
    tick();
    tick();
    check("rst_sync",  32'(SYNC_BUS), 32'h00);
    check("rst_pulse", 32'(ENABLE_PULSE), 0);
    check("rst_valid", 32'(BUS_VALID), 0);
    check("rst_ovr",   32'(OVERRUN), 0);
    check("rst_drop",  32'(DROP_CNT), 0);
    RST = 1'b1;
    tick();

    // Basic capture, enable held 5 cycles
    pulse_cnt = 0;
    raise_en(8'hA5);
    check("lat_e2_pulse", 32'(ENABLE_PULSE), 0);
    tick();
    check("cap_pulse", 32'(ENABLE_PULSE), 1);
    check("cap_sync",  32'(SYNC_BUS), 32'hA5);
    check("cap_valid", 32'(BUS_VALID), 1);
    tick();
    check("cap_pulse_off", 32'(ENABLE_PULSE), 0);
    tick();
    lower_en();
    check("cap_one_pulse", 32'(pulse_cnt), 1);

    // Consume
    BUS_READY = 1'b1;
    tick();
    BUS_READY = 1'b0;
    check("cons_valid", 32'(BUS_VALID), 0);
    check("cons_sync",  32'(SYNC_BUS), 32'hA5);
    BUS_READY = 1'b1;
    tick();
    BUS_READY = 1'b0;
    check("idle_ready_valid", 32'(BUS_VALID), 0);
    check("idle_ready_sync",  32'(SYNC_BUS), 32'hA5);

    // Refill, then overrun
    raise_en(8'hA5);
    tick();
    lower_en();
    check("refill_valid", 32'(BUS_VALID), 1);
    pulse_cnt = 0;
    raise_en(8'h3C);
    tick();
    check("ovr_sync",  32'(SYNC_BUS), 32'hA5);
    check("ovr_flag",  32'(OVERRUN), 1);
    check("ovr_drop",  32'(DROP_CNT), 1);
    check("ovr_pulse", 32'(ENABLE_PULSE), 0);
    lower_en();
    for (int i = 0; i < 20; i++) begin
      raise_en(8'(i));
      tick();
      lower_en();
    end
    check("sat_drop",  32'(DROP_CNT), 15);
    check("sat_ovr",   32'(OVERRUN), 1);
    check("sat_sync",  32'(SYNC_BUS), 32'hA5);
    check("sat_valid", 32'(BUS_VALID), 1);
    check("sat_no_pulse", 32'(pulse_cnt), 0);

    // Clear coinciding with a drop: set wins, count restarts at 1
    raise_en(8'h77);
    OVERRUN_CLR = 1'b1;
    tick();
    OVERRUN_CLR = 1'b0;
    check("clrdrop_ovr",  32'(OVERRUN), 1);
    check("clrdrop_drop", 32'(DROP_CNT), 1);
    check("clrdrop_sync", 32'(SYNC_BUS), 32'hA5);
    lower_en();
    OVERRUN_CLR = 1'b1;
    tick();
    OVERRUN_CLR = 1'b0;
    check("clr_ovr",  32'(OVERRUN), 0);
    check("clr_drop", 32'(DROP_CNT), 0);

    // One drop to make the count non-zero, then back-to-back consume+capture
    raise_en(8'h55);
    tick();
    lower_en();
    check("drop1_cnt", 32'(DROP_CNT), 1);
    pulse_cnt = 0;
    raise_en(8'h3C);
    BUS_READY = 1'b1;
    tick();
    BUS_READY = 1'b0;
    check("b2b_sync",  32'(SYNC_BUS), 32'h3C);
    check("b2b_valid", 32'(BUS_VALID), 1);
    check("b2b_pulse", 32'(ENABLE_PULSE), 1);
    check("b2b_drop",  32'(DROP_CNT), 1);
    lower_en();
    check("b2b_one_pulse", 32'(pulse_cnt), 1);

    // Reset mid-flight, enable still high at release
    UNSYNC_BUS = 8'h96;
    BUS_ENABLE = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    check("mid_rst_sync",  32'(SYNC_BUS), 0);
    check("mid_rst_valid", 32'(BUS_VALID), 0);
    check("mid_rst_ovr",   32'(OVERRUN), 0);
    check("mid_rst_drop",  32'(DROP_CNT), 0);
    check("mid_rst_pulse", 32'(ENABLE_PULSE), 0);
    tick();
    tick();
    pulse_cnt = 0;
    RST = 1'b1;
    tick();
    tick();
    check("rel_e2_pulse", 32'(ENABLE_PULSE), 0);
    tick();
    check("rel_pulse", 32'(ENABLE_PULSE), 1);
    check("rel_valid", 32'(BUS_VALID), 1);
    check("rel_sync",  32'(SYNC_BUS), 32'h96);
    tick();
    tick();
    tick();
    check("rel_one_pulse", 32'(pulse_cnt), 1);
    lower_en();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
